// File: rtl/preg.sv
// Pipeline register stage with a two-entry skid buffer: main drives the outputs,
// skid catches one extra entry so upstream ready can be registered.
module preg #(
  parameter int unsigned DW     = 32,
  parameter logic [31:0] PC_RST = 32'h3000,
  parameter int unsigned CW     = 16
) (
  input  logic          preg_clk_i,
  input  logic          preg_clr_i,
  input  logic          preg_flush_i,
  input  logic          preg_vld_i,
  output logic          preg_rdy_o,
  input  logic [31:0]   preg_str_i,
  input  logic [31:0]   preg_pc4_i,
  input  logic [DW-1:0] preg_dat_i,
  output logic          preg_vld_o,
  input  logic          preg_rdy_i,
  output logic [31:0]   preg_str_o,
  output logic [31:0]   preg_pc4_o,
  output logic [DW-1:0] preg_dat_o,
  output logic [CW-1:0] preg_bub_o
);

  localparam int unsigned SW = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [CW-1:0] BUB_MAX = {CW{1'b1}};

  state_e          state_q = ST_EMPTY;
  state_e          state_d;
  logic            rdy_q = 1'b1;
  logic            rdy_d;

  logic [SW-1:0]   main_str_q = '0;
  logic [SW-1:0]   main_pc4_q = PC_RST;
  logic [DW-1:0]   main_dat_q = '0;
  logic [SW-1:0]   main_str_d;
  logic [SW-1:0]   main_pc4_d;
  logic [DW-1:0]   main_dat_d;

  logic [SW-1:0]   skid_str_q = '0;
  logic [SW-1:0]   skid_pc4_q = PC_RST;
  logic [DW-1:0]   skid_dat_q = '0;
  logic [SW-1:0]   skid_str_d;
  logic [SW-1:0]   skid_pc4_d;
  logic [DW-1:0]   skid_dat_d;

  logic [CW-1:0]   bub_q = '0;
  logic [CW-1:0]   bub_d;

  logic            acc_c;
  logic            iss_c;
  logic            vld_c;

  assign vld_c = (state_q != ST_EMPTY);
  assign acc_c = preg_vld_i & rdy_q;
  assign iss_c = vld_c & preg_rdy_i;

  // Next-state, entry movement and registered-ready computation
  always_comb begin
    state_d    = state_q;
    main_str_d = main_str_q;
    main_pc4_d = main_pc4_q;
    main_dat_d = main_dat_q;
    skid_str_d = skid_str_q;
    skid_pc4_d = skid_pc4_q;
    skid_dat_d = skid_dat_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (acc_c) begin
          state_d    = ST_ONE;
          main_str_d = preg_str_i;
          main_pc4_d = preg_pc4_i;
          main_dat_d = preg_dat_i;
        end
      end
      ST_ONE: begin
        if (acc_c && iss_c) begin
          main_str_d = preg_str_i;
          main_pc4_d = preg_pc4_i;
          main_dat_d = preg_dat_i;
        end else if (acc_c) begin
          state_d    = ST_TWO;
          skid_str_d = preg_str_i;
          skid_pc4_d = preg_pc4_i;
          skid_dat_d = preg_dat_i;
        end else if (iss_c) begin
          // main returns to NOP so the outputs read as a bubble without muxing
          state_d    = ST_EMPTY;
          main_str_d = '0;
          main_pc4_d = PC_RST;
          main_dat_d = '0;
        end
      end
      ST_TWO: begin
        if (iss_c) begin
          state_d    = ST_ONE;
          main_str_d = skid_str_q;
          main_pc4_d = skid_pc4_q;
          main_dat_d = skid_dat_q;
          skid_str_d = '0;
          skid_pc4_d = PC_RST;
          skid_dat_d = '0;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (preg_flush_i) begin
      state_d    = ST_EMPTY;
      main_str_d = '0;
      main_pc4_d = PC_RST;
      main_dat_d = '0;
      skid_str_d = '0;
      skid_pc4_d = PC_RST;
      skid_dat_d = '0;
    end

    rdy_d = (state_d != ST_TWO);
  end

  // Saturating count of cycles where downstream was ready but got nothing
  always_comb begin
    bub_d = bub_q;
    if (!vld_c && preg_rdy_i && (bub_q != BUB_MAX)) begin
      bub_d = bub_q + CW'(1);
    end
  end

  always_ff @(posedge preg_clk_i) begin
    if (preg_clr_i) begin
      state_q    <= ST_EMPTY;
      rdy_q      <= 1'b1;
      main_str_q <= '0;
      main_pc4_q <= PC_RST;
      main_dat_q <= '0;
      skid_str_q <= '0;
      skid_pc4_q <= PC_RST;
      skid_dat_q <= '0;
      bub_q      <= '0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      main_str_q <= main_str_d;
      main_pc4_q <= main_pc4_d;
      main_dat_q <= main_dat_d;
      skid_str_q <= skid_str_d;
      skid_pc4_q <= skid_pc4_d;
      skid_dat_q <= skid_dat_d;
      bub_q      <= bub_d;
    end
  end

  assign preg_vld_o = vld_c;
  assign preg_rdy_o = rdy_q;
  assign preg_str_o = main_str_q;
  assign preg_pc4_o = main_pc4_q;
  assign preg_dat_o = main_dat_q;
  assign preg_bub_o = bub_q;

endmodule
